// File: rtl/trail_ram_write_arbiter.sv
`timescale 1ns/1ps
// Sole owner of the trail RAM write port. A full-frame clear engine and two
// player block painters (BLOCK_W x BLOCK_H each) share the port.
module trail_ram_write_arbiter #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int BLOCK_W = 8,
  parameter int BLOCK_H = 8,
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 8
) (
  input  logic              VGA_CLK,
  input  logic              reset,
  input  logic              clear_req,
  input  logic              p1_req,
  input  logic [9:0]        p1_x,
  input  logic [9:0]        p1_y,
  input  logic [DATA_W-1:0] p1_code,
  output logic              p1_ack,
  input  logic              p2_req,
  input  logic [9:0]        p2_x,
  input  logic [9:0]        p2_y,
  input  logic [DATA_W-1:0] p2_code,
  output logic              p2_ack,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              clear_done,
  output logic [1:0]        dbg_state_o
);
  // Handshake: pN_req is held with stable x/y/code until pN_ack; pN_ack is a
  // one-cycle pulse, during which a still-high pN_req is ignored.
  typedef enum logic [1:0] {S_CLEAR = 2'd0, S_IDLE = 2'd1, S_DRAW = 2'd2} state_t;

  localparam int                CW           = 8;
  localparam logic [ADDR_W-1:0] FRAME_PIXELS = ADDR_W'(H_RES * V_RES);
  localparam logic [ADDR_W-1:0] ROW_STEP     = ADDR_W'(H_RES - (BLOCK_W - 1));
  localparam logic [CW-1:0]     DX_LAST      = CW'(BLOCK_W - 1);
  localparam logic [CW-1:0]     DY_LAST      = CW'(BLOCK_H - 1);
  localparam logic [10:0]       H_LIM        = 11'(H_RES);
  localparam logic [10:0]       V_LIM        = 11'(V_RES);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              last_p2_q, last_p2_d;
  logic              owner_p2_q, owner_p2_d;
  logic [10:0]       x0_q, x0_d;
  logic [10:0]       cx_q, cx_d;
  logic [10:0]       cy_q, cy_d;
  logic [CW-1:0]     dx_q, dx_d;
  logic [CW-1:0]     dy_q, dy_d;
  logic [DATA_W-1:0] code_q, code_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              p1_ack_q, p1_ack_d;
  logic              p2_ack_q, p2_ack_d;
  logic              busy_q, busy_d;
  logic              clear_done_q, clear_done_d;

  logic              req1, req2, gnt1, gnt2;
  logic [9:0]        gx, gy;
  logic [DATA_W-1:0] gcode;
  logic [ADDR_W-1:0] gbase;

  always_comb begin
    req1  = p1_req && !p1_ack_q;
    req2  = p2_req && !p2_ack_q;
    gnt2  = req2 && (!req1 || !last_p2_q);
    gnt1  = req1 && !gnt2;
    gx    = gnt2 ? p2_x : p1_x;
    gy    = gnt2 ? p2_y : p1_y;
    gcode = gnt2 ? p2_code : p1_code;
    gbase = ADDR_W'(gy) * ADDR_W'(H_RES) + ADDR_W'(gx);
  end

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    last_p2_d    = last_p2_q;
    owner_p2_d   = owner_p2_q;
    x0_d         = x0_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    code_d       = code_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    p1_ack_d     = 1'b0;
    p2_ack_d     = 1'b0;
    clear_done_d = 1'b0;

    // A clear request wins in every state and drops any block in flight.
    if (clear_req) begin
      state_d   = S_CLEAR;
      wr_en_d   = 1'b1;
      wr_addr_d = '0;
      wr_data_d = '0;
      clr_cnt_d = ADDR_W'(1);
    end else begin
      case (state_q)
        S_CLEAR: begin
          if (clr_cnt_q == FRAME_PIXELS) begin
            clear_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = clr_cnt_q;
            wr_data_d = '0;
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
          end
        end
        S_IDLE: begin
          if (gnt1 || gnt2) begin
            owner_p2_d = gnt2;
            last_p2_d  = gnt2;
            x0_d       = {1'b0, gx};
            cx_d       = {1'b0, gx};
            cy_d       = {1'b0, gy};
            dx_d       = '0;
            dy_d       = '0;
            code_d     = gcode;
            wr_addr_d  = gbase;
            wr_data_d  = gcode;
            wr_en_d    = ({1'b0, gx} < H_LIM) && ({1'b0, gy} < V_LIM);
            state_d    = S_DRAW;
          end
        end
        S_DRAW: begin
          if (dx_q == DX_LAST && dy_q == DY_LAST) begin
            p1_ack_d = !owner_p2_q;
            p2_ack_d = owner_p2_q;
            state_d  = S_IDLE;
          end else begin
            // The address walks every pixel, clipped or not, so it stays in step.
            if (dx_q == DX_LAST) begin
              dx_d      = '0;
              dy_d      = dy_q + CW'(1);
              cx_d      = x0_q;
              cy_d      = cy_q + 11'(1);
              wr_addr_d = wr_addr_q + ROW_STEP;
            end else begin
              dx_d      = dx_q + CW'(1);
              cx_d      = cx_q + 11'(1);
              wr_addr_d = wr_addr_q + ADDR_W'(1);
            end
            wr_en_d   = (cx_d < H_LIM) && (cy_d < V_LIM);
            wr_data_d = code_q;
          end
        end
        default: state_d = S_CLEAR;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      state_q      <= S_CLEAR;
      clr_cnt_q    <= '0;
      last_p2_q    <= 1'b1;
      owner_p2_q   <= 1'b0;
      x0_q         <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      dx_q         <= '0;
      dy_q         <= '0;
      code_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      p1_ack_q     <= 1'b0;
      p2_ack_q     <= 1'b0;
      busy_q       <= 1'b1;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      last_p2_q    <= last_p2_d;
      owner_p2_q   <= owner_p2_d;
      x0_q         <= x0_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      code_q       <= code_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      p1_ack_q     <= p1_ack_d;
      p2_ack_q     <= p2_ack_d;
      busy_q       <= busy_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign p1_ack      = p1_ack_q;
  assign p2_ack      = p2_ack_q;
  assign busy        = busy_q;
  assign clear_done  = clear_done_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/trail_ram_write_arbiter.md
Name: trail_ram_write_arbiter

Overview:
- Sole owner of the write port of the trail RAM: the 8-bit-per-pixel, 640x480 framebuffer that the VGA path reads back and the players use for collision lookup.
- Shares the write port between two player drawing requesters and an internal full-frame clear engine.
- Each player request paints one BLOCK_W x BLOCK_H block.
- Clear runs automatically after reset and on each game restart (reiniciar).

Parameters:
- H_RES, 640, pixels per line, also the RAM row stride.
- V_RES, 480, visible lines.
- BLOCK_W, 8, block width in pixels.
- BLOCK_H, 8, block height in lines.
- ADDR_W, 19, RAM address width.
- DATA_W, 8, RAM data width.

Ports:
- VGA_CLK  input  1  sole clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- clear_req  input  1  level or pulse; starts or restarts the frame clear.
- p1_req  input  1  player 1 block-write request; held until p1_ack.
- p1_x  input  10  block top-left x.
- p1_y  input  10  block top-left y.
- p1_code  input  DATA_W  value written to every pixel of the block.
- p1_ack  output  1  one-cycle pulse: block complete.
- p2_req, p2_x, p2_y, p2_code, p2_ack: same as the p1 signals, for player 2.
- wr_en  output  1  RAM write enable.
- wr_addr  output  ADDR_W  RAM write address.
- wr_data  output  DATA_W  RAM write data.
- busy  output  1  high whenever state is not IDLE.
- clear_done  output  1  one-cycle pulse after the last clear write.

Behaviour:
- All outputs are registered.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, p1_ack=0, p2_ack=0, clear_done=0, busy=1.
- Reset loads state=CLEAR with the clear counter at 0 and last_grant=P2, so player 1 wins the first tie.
- FSM states and transitions:
  - CLEAR: one write per cycle with wr_en=1, wr_data=0, wr_addr=0..H_RES*V_RES-1 (307200 cycles). The cycle after the final address: clear_done=1 for one cycle, then go to IDLE.
  - IDLE: clear_req has the highest priority and goes to CLEAR with the counter at 0. Otherwise, if exactly one pN_req is high, grant it. If both are high, grant the player that is not last_grant. On grant, latch x, y and code, update last_grant, compute base = y*H_RES + x, go to DRAW.
  - DRAW: exactly BLOCK_W*BLOCK_H cycles, scanned row-major (dx fastest, then dy).
    - wr_addr = base + dy*H_RES + dx, produced incrementally: +1 per pixel, +H_RES-(BLOCK_W-1) at the end of each row. No multiplier in the loop.
    - wr_data = latched code.
    - Clipping: if x+dx >= H_RES or y+dy >= V_RES, wr_en=0 for that cycle; the cycle still counts. The block always takes 64 cycles, even when fully off-screen.
    - The cycle after the last pixel: pN_ack=1 for one cycle, wr_en=0, return to IDLE.
- Latency:
  - Request sampled in IDLE at cycle n.
  - Writes occur in cycles n+1..n+64.
  - Ack occurs at n+65.
  - The earliest next grant is n+65, from IDLE.
- Double-grant guard: in the cycle that pN_ack is high, IDLE ignores pN_req. The requester drops req in the cycle after ack.
- clear_req during DRAW:
  - The active block is aborted immediately; no ack is issued for it.
  - Go to CLEAR at address 0.
  - Requests still high after clear_done are served normally.
- clear_req during CLEAR restarts the sweep at address 0; clear_done is issued only at the end of a complete uninterrupted sweep.
- Inputs pN_x, pN_y and pN_code may change after grant without effect.
- Arithmetic:
  - base and the address counter are ADDR_W wide.
  - Out-of-range coordinates never wrap into valid addresses; clipping suppresses the write.
- Asynchronous reset mid-DRAW or mid-CLEAR: return to reset values at once and restart CLEAR.

Test Plan:
- Reset release, no requests -> busy=1, wr_en=1 with wr_addr=0..307199 and wr_data=0, clear_done pulse at cycle 307200, then busy=0 and wr_en=0.
- After clear, p1_req with (216,240) and code 1 -> 64 writes, first wr_addr 153816, row 0 ends at 153823, row 1 starts at 154456, last 158303, all data 1; p1_ack at request+65.
- p1_req and p2_req rise in the same cycle, both held high and re-raised after each ack -> grants P1, P2, P1, P2; no back-to-back double grant to one player.
- p2_req with (636,476) -> 64 DRAW cycles; only the 4x4 on-screen pixels written (16 writes, first 305276); p2_ack still at request+65.
- clear_req at the 20th pixel of a p1 block -> wr_data=0 and wr_addr=0 on the next cycle, no p1_ack; p1_req held high is granted after clear_done.
- clear_req pulsed at clear address 1000 -> sweep restarts at 0; clear_done only after the full 307200-cycle sweep.
